// File: rtl/pipe_control.sv
// Pipelined LEGv8 control: decodes the ID instruction, carries control bundles through
// ID/EX, EX/MEM and MEM/WB, and handles load-use stalls, branch flushes and event counters.
module pipe_control #(
    parameter bit          HAZARD_EN = 1'b1,
    parameter int unsigned CNT_W     = 16,
    parameter logic [4:0]  ZERO_REG  = 5'd31
) (
    input  logic             CLK,
    input  logic             resetl,
    input  logic [31:0]      id_instr,
    input  logic             id_valid,
    input  logic             ex_branch_taken,
    output logic             id_reg2loc,
    output logic [2:0]       id_signop,
    output logic             ex_alusrc,
    output logic [3:0]       ex_aluop,
    output logic             ex_branch,
    output logic             ex_uncond_branch,
    output logic             mem_memread,
    output logic             mem_memwrite,
    output logic             wb_regwrite,
    output logic             wb_mem2reg,
    output logic [4:0]       wb_rd,
    output logic             stall,
    output logic             flush_ifid,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef struct packed {
        logic       alusrc;
        logic [3:0] aluop;
        logic       branch;
        logic       uncond_branch;
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic       mem2reg;
        logic [4:0] rd;
    } idex_t;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic       mem2reg;
        logic [4:0] rd;
    } exmem_t;

    typedef struct packed {
        logic       regwrite;
        logic       mem2reg;
        logic [4:0] rd;
    } memwb_t;

    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [10:0] opcode;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [4:0]  rt;
    logic        unused_instr_bits;

    assign opcode = id_instr[31:21];
    assign rm     = id_instr[20:16];
    assign rn     = id_instr[9:5];
    assign rt     = id_instr[4:0];
    // Shift amount / immediate bits never affect control.
    assign unused_instr_bits = ^id_instr[15:10];

    idex_t  dec;
    logic   reads_rn;
    logic   reads_rm;
    logic   reads_rt;

    idex_t  idex_q, idex_d;
    exmem_t exmem_q, exmem_d;
    memwb_t memwb_q, memwb_d;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic src_hit;
    logic load_use;

    // Priority decode: first matching pattern wins.
    always_comb begin
        dec        = '0;
        id_reg2loc = 1'b0;
        id_signop  = 3'b000;
        reads_rn   = 1'b0;
        reads_rm   = 1'b0;
        reads_rt   = 1'b0;
        if (id_valid) begin
            dec.rd = id_instr[4:0];
            casez (opcode)
                11'b?0001010???: begin // AND
                    dec.aluop    = 4'b0000;
                    dec.regwrite = 1'b1;
                    reads_rn     = 1'b1;
                    reads_rm     = 1'b1;
                end
                11'b?0101010???: begin // ORR
                    dec.aluop    = 4'b0001;
                    dec.regwrite = 1'b1;
                    reads_rn     = 1'b1;
                    reads_rm     = 1'b1;
                end
                11'b?0?01011???: begin // ADD
                    dec.aluop    = 4'b0010;
                    dec.regwrite = 1'b1;
                    reads_rn     = 1'b1;
                    reads_rm     = 1'b1;
                end
                11'b?1?01011???: begin // SUB
                    dec.aluop    = 4'b0110;
                    dec.regwrite = 1'b1;
                    reads_rn     = 1'b1;
                    reads_rm     = 1'b1;
                end
                11'b?0?10001???: begin // ADDI
                    dec.alusrc   = 1'b1;
                    dec.aluop    = 4'b0010;
                    dec.regwrite = 1'b1;
                    reads_rn     = 1'b1;
                end
                11'b?1?10001???: begin // SUBI
                    dec.alusrc   = 1'b1;
                    dec.aluop    = 4'b0110;
                    dec.regwrite = 1'b1;
                    reads_rn     = 1'b1;
                end
                11'b110100101??: begin // MOVZ, shift field selects the half-word
                    dec.alusrc   = 1'b1;
                    dec.aluop    = 4'b0111;
                    dec.regwrite = 1'b1;
                    id_signop    = {1'b1, opcode[1:0]};
                end
                11'b?00101?????: begin // B
                    dec.uncond_branch = 1'b1;
                    id_signop         = 3'b010;
                end
                11'b?011010????: begin // CBZ
                    id_reg2loc = 1'b1;
                    dec.branch = 1'b1;
                    dec.aluop  = 4'b0111;
                    id_signop  = 3'b011;
                    reads_rt   = 1'b1;
                end
                11'b??111000010: begin // LDUR
                    dec.alusrc   = 1'b1;
                    dec.mem2reg  = 1'b1;
                    dec.memread  = 1'b1;
                    dec.regwrite = 1'b1;
                    dec.aluop    = 4'b0010;
                    id_signop    = 3'b001;
                    reads_rn     = 1'b1;
                end
                11'b??111000000: begin // STUR
                    id_reg2loc = 1'b1;
                    dec.alusrc   = 1'b1;
                    dec.memwrite = 1'b1;
                    dec.aluop    = 4'b0010;
                    id_signop    = 3'b001;
                    reads_rn     = 1'b1;
                    reads_rt     = 1'b1;
                end
                default: begin
                    dec.rd = 5'd0;
                end
            endcase
        end
    end

    // Only sources the ID instruction really reads can create a hazard.
    always_comb begin
        src_hit = (reads_rn && (idex_q.rd == rn)) ||
                  (reads_rm && (idex_q.rd == rm)) ||
                  (reads_rt && (idex_q.rd == rt));
        load_use = idex_q.memread && (idex_q.rd != ZERO_REG) && src_hit;
    end

    // Flush wins over stall: the squashed instruction cannot need the load.
    assign stall      = HAZARD_EN && load_use && !ex_branch_taken;
    assign flush_ifid = ex_branch_taken;

    always_comb begin
        idex_d = (stall || ex_branch_taken) ? '0 : dec;

        exmem_d.memread  = idex_q.memread;
        exmem_d.memwrite = idex_q.memwrite;
        exmem_d.regwrite = idex_q.regwrite;
        exmem_d.mem2reg  = idex_q.mem2reg;
        exmem_d.rd       = idex_q.rd;

        memwb_d.regwrite = exmem_q.regwrite;
        memwb_d.mem2reg  = exmem_q.mem2reg;
        memwb_d.rd       = exmem_q.rd;
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && (stall_cnt_q != CntMax)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (ex_branch_taken && (flush_cnt_q != CntMax)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            idex_q      <= '0;
            exmem_q     <= '0;
            memwb_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            idex_q      <= idex_d;
            exmem_q     <= exmem_d;
            memwb_q     <= memwb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_alusrc        = idex_q.alusrc;
    assign ex_aluop         = idex_q.aluop;
    assign ex_branch        = idex_q.branch;
    assign ex_uncond_branch = idex_q.uncond_branch;
    assign mem_memread      = exmem_q.memread;
    assign mem_memwrite     = exmem_q.memwrite;
    assign wb_regwrite      = memwb_q.regwrite;
    assign wb_mem2reg       = memwb_q.mem2reg;
    assign wb_rd            = memwb_q.rd;
    assign stall_cnt        = stall_cnt_q;
    assign flush_cnt        = flush_cnt_q;

endmodule
